mem_ctrl: RTL

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port RAM access sequencer between the CPU (MAR/MDR) and a
// word-addressed RAM that can insert wait states.
//
// Ports
//   clk, clr            clock, synchronous active-high reset
//   Read, Write         CPU requests, sampled only while idle
//   addr, wdata         word address (MAR) and write data (MDR Q)
//   Mdatain             registered read data toward the MDR
//   mdr_load            one-cycle MDR load strobe after a successful read
//   done, err           one-cycle completion / error pulses
//   busy                high whenever an access or response is in flight
//   ram_addr, ram_wdata latched address / write data driven to the RAM
//   ram_re, ram_we      RAM read / write enables
//   ram_rdata, ram_ready RAM read data and access-complete handshake
module mem_ctrl #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              Read,
    input  logic              Write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       Mdatain,
    output logic              mdr_load,
    output logic              done,
    output logic              err,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_re,
    output logic              ram_we,
    input  logic [31:0]       ram_rdata,
    input  logic              ram_ready
);

    typedef enum logic [2:0] {IDLE, RD, WR, RESP, ERR} state_t;

    // Last wait-count value before the access is abandoned.
    localparam logic [4:0] CNT_LAST = 5'(TIMEOUT - 1);

    state_t     state, nxt;
    logic [4:0] wcnt;
    logic       from_rd;   // RESP was entered from RD, so the MDR gets loaded

    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (Read && !Write)      nxt = RD;
                else if (Write && !Read) nxt = WR;
                else if (Read && Write)  nxt = ERR;
            end
            // Completion wins over timeout when both happen in the same cycle.
            RD, WR: begin
                if (ram_ready)             nxt = RESP;
                else if (wcnt == CNT_LAST) nxt = ERR;
            end
            RESP:    nxt = IDLE;
            ERR:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= IDLE;
            wcnt      <= '0;
            from_rd   <= 1'b0;
            Mdatain   <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            state <= nxt;
            case (state)
                IDLE: begin
                    // Conflicting Read+Write leaves the latches untouched.
                    if (Read ^ Write) begin
                        ram_addr <= addr;
                        wcnt     <= '0;
                    end
                    if (Write && !Read) ram_wdata <= wdata;
                end
                RD: begin
                    if (ram_ready) begin
                        Mdatain <= ram_rdata;
                        from_rd <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 5'd1;
                    end
                end
                WR: begin
                    if (ram_ready) from_rd <= 1'b0;
                    else           wcnt    <= wcnt + 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign ram_re   = (state == RD);
    assign ram_we   = (state == WR);
    assign done     = (state == RESP);
    assign mdr_load = (state == RESP) && from_rd;
    assign err      = (state == ERR);

endmodule
